// File: rtl/pipe_regs_pkg.sv
// pipe_regs_pkg: shared default width, stage limit and occupancy sizing helper
package pipe_regs_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int MAX_STAGES = 8;
  function automatic int occ_w(input int stages);
    return $clog2(stages + 1);
  endfunction
endpackage

// File: rtl/pipe_regs_slice.sv
// pipe_regs_slice: one valid/data register pair; clk, rst, clr_i squash, ld_i load, v_i/d_i source, v_o/d_o state
module pipe_regs_slice
  import pipe_regs_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             v_o,
  output logic [WIDTH-1:0] d_o
);
  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;
  always_comb begin
    v_d = clr_i ? 1'b0 : ld_i ? v_i : v_q;
    d_d = (ld_i & v_i) ? d_i : d_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= RESET_VAL;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end
  assign v_o = v_q;
  assign d_o = d_q;
endmodule

// File: rtl/pipe_regs.sv
// pipe_regs: STAGES-deep valid/ready pipeline with flush; ports clk rst flush in_valid/in_ready/in_data out_valid/out_ready/out_data occupancy
module pipe_regs
  import pipe_regs_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit BUBBLE_COLLAPSE = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [occ_w(STAGES)-1:0]    occupancy
);
  localparam int OW = occ_w(STAGES);
  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("pipe_regs: STAGES must be in 1..%0d", MAX_STAGES);
  end
  logic [STAGES:0]  vc;
  logic [STAGES:0]  rdy;
  logic [WIDTH-1:0] dc [STAGES+1];
  logic             en;
  assign vc[0] = in_valid;
  assign dc[0] = in_data;
  assign en = ~vc[STAGES] | out_ready;
  always_comb begin
    rdy = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--)
      rdy[k] = BUBBLE_COLLAPSE ? (~vc[k+1] | rdy[k+1]) : en;
  end
  genvar i;
  for (i = 0; i < STAGES; i++) begin : g_slice
    pipe_regs_slice #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_slice (
      .clk   (clk),
      .rst   (rst),
      .clr_i (flush),
      .ld_i  (rdy[i] & ~flush),
      .v_i   (vc[i]),
      .d_i   (dc[i]),
      .v_o   (vc[i+1]),
      .d_o   (dc[i+1])
    );
  end
  always_comb begin
    occupancy = '0;
    for (int k = 1; k <= STAGES; k++)
      occupancy = occupancy + OW'(vc[k]);
  end
  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = vc[STAGES] & ~flush;
  assign out_data  = dc[STAGES];
endmodule
